pipe_mode_controller: RTL and testbench

Sequences one bank of selectable/extendable pipeline registers in the FC-DNN accelerator datapath. Accepts per-layer jobs (mode + beat count) over a valid/ready handshake, drives the bank's 2-bit mode select, gates upstream beats, and regenerates a valid/last tag aligned to the selected pipe latency. Guarantees the mode never changes while data is in flight.

---
 rtl/fcdnn_pipe_pkg.sv | 11 +
 rtl/pipe_mode_controller_if.sv | 22 ++
 rtl/pipe_tag_delay.sv | 36 +++
 rtl/pipe_mode_controller.sv | 71 +++++++
 tb/tb_pipe_mode_controller.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fcdnn_pipe_pkg.sv
// fcdnn_pipe_pkg: pipe bank mode encodings, controller states and mode-to-latency mapping
package fcdnn_pipe_pkg;
    localparam logic [1:0] DISABLED     = 2'b00;
    localparam logic [1:0] NOT_EXTENDED = 2'b10;
    localparam logic [1:0] EXTENDED     = 2'b11;
    localparam logic [1:0] ILLEGAL      = 2'b01;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
    function automatic int mode_latency(input logic [1:0] mode, input int extra);
        return mode == EXTENDED ? extra + 7 : mode == NOT_EXTENDED ? extra : 0;
    endfunction
endpackage

// File: rtl/pipe_mode_controller_if.sv
// pipe_mode_controller_if: job config, upstream beat handshake and pipe bank status signals
interface pipe_mode_controller_if #(parameter int COUNT_W = 16);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_mode;
    logic [COUNT_W-1:0] cfg_beats;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         pipe_mode;
    logic               out_valid;
    logic               done;
    logic               busy;
    logic               err_mode;
    modport master (
        output cfg_valid, cfg_mode, cfg_beats, in_valid,
        input  cfg_ready, in_ready, pipe_mode, out_valid, done, busy, err_mode
    );
    modport slave (
        input  cfg_valid, cfg_mode, cfg_beats, in_valid,
        output cfg_ready, in_ready, pipe_mode, out_valid, done, busy, err_mode
    );
endinterface

// File: rtl/pipe_tag_delay.sv
// pipe_tag_delay: valid/last tag shift register tapped at the selected latency, zero-latency bypass
module pipe_tag_delay #(
    parameter int DEPTH = 9,
    parameter int LAT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_pll,
    input  logic             rst_n,
    input  logic [LAT_W-1:0] i_lat,
    input  logic             i_valid,
    input  logic             i_last,
    output logic             o_valid,
    output logic             o_last
);
    logic [DEPTH-1:0] r_valid_sr, r_last_sr;
    logic [DEPTH-1:0] w_keep, w_tap;
    // stages past the tap are forced empty so the bank is clean once done fires
    always_comb begin
        w_keep = '0;
        w_tap  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_keep[i] = i < int'(i_lat);
            w_tap[i]  = i == int'(i_lat) - 1;
        end
    end
    always_ff @(posedge clk_pll) begin
        if (!rst_n) begin
            r_valid_sr <= '0;
            r_last_sr  <= '0;
        end else begin
            r_valid_sr <= {r_valid_sr[DEPTH-2:0], i_valid} & w_keep;
            r_last_sr  <= {r_last_sr[DEPTH-2:0], i_last} & w_keep;
        end
    end
    assign o_valid = i_lat == '0 ? i_valid : |(r_valid_sr & w_tap);
    assign o_last  = i_lat == '0 ? i_last  : |(r_last_sr & w_tap);
endmodule

// File: rtl/pipe_mode_controller.sv
// pipe_mode_controller: sequences pipe bank mode per job and regenerates valid/last; PIPE_CTRL_BACKTOBACK_EN allows same-mode jobs during drain
module pipe_mode_controller
    import fcdnn_pipe_pkg::*;
#(
    parameter int NUM_OF_EXTRA_PIPES = 2,
    parameter int COUNT_W            = 16
) (
    input logic                   clk_pll,
    input logic                   rst_n,
    pipe_mode_controller_if.slave bus
);
    localparam int DEPTH = NUM_OF_EXTRA_PIPES + 7;
    localparam int LAT_W = $clog2(DEPTH + 1);
    state_t             r_state;
    logic [1:0]         r_mode;
    logic [COUNT_W-1:0] r_remain;
    logic               r_err;
    logic               r_zdone;
    logic [LAT_W-1:0]   w_lat;
    logic               w_cfg_ready, w_accept, w_illegal, w_beat, w_last;
    logic               w_tag_valid, w_tag_done;
    assign w_lat = LAT_W'(mode_latency(r_mode, NUM_OF_EXTRA_PIPES));
`ifdef PIPE_CTRL_BACKTOBACK_EN
    assign w_cfg_ready = r_state == IDLE || (r_state == DRAIN && bus.cfg_mode == r_mode);
`else
    assign w_cfg_ready = r_state == IDLE;
`endif
    assign w_accept  = bus.cfg_valid && w_cfg_ready;
    assign w_illegal = bus.cfg_mode == ILLEGAL;
    assign w_beat    = bus.in_valid && r_state == STREAM;
    assign w_last    = w_beat && r_remain == COUNT_W'(1);
    always_ff @(posedge clk_pll) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mode   <= DISABLED;
            r_remain <= '0;
            r_err    <= 1'b0;
            r_zdone  <= 1'b0;
        end else begin
            r_zdone <= w_accept && !w_illegal && bus.cfg_beats == '0;
            if (w_accept && w_illegal) begin
                r_err <= 1'b1;
            end else if (w_accept) begin
                r_mode   <= bus.cfg_mode;
                r_remain <= bus.cfg_beats;
                r_state  <= bus.cfg_beats != '0 ? STREAM : (r_state == DRAIN && w_tag_done) ? IDLE : r_state;
            end else if (w_beat) begin
                r_remain <= r_remain - COUNT_W'(1);
                if (w_last) r_state <= w_lat == '0 ? IDLE : DRAIN;
            end else if (r_state == DRAIN && w_tag_done) begin
                r_state <= IDLE;
            end
        end
    end
    pipe_tag_delay #(.DEPTH(DEPTH), .LAT_W(LAT_W)) u_tag (
        .clk_pll (clk_pll),
        .rst_n   (rst_n),
        .i_lat   (w_lat),
        .i_valid (w_beat),
        .i_last  (w_last),
        .o_valid (w_tag_valid),
        .o_last  (w_tag_done)
    );
    assign bus.cfg_ready = w_cfg_ready;
    assign bus.in_ready  = r_state == STREAM;
    assign bus.pipe_mode = r_mode;
    assign bus.out_valid = w_tag_valid;
    assign bus.done      = w_tag_done || r_zdone;
    assign bus.busy      = r_state != IDLE;
    assign bus.err_mode  = r_err;
endmodule

// File: tb/tb_pipe_mode_controller.sv
// tb_pipe_mode_controller: directed per-cycle checks of pipe_mode_controller with NUM_OF_EXTRA_PIPES=2
module tb_pipe_mode_controller;
    logic clk_pll = 1'b0;
    logic rst_n   = 1'b0;
    int checks   = 0;
    int failures = 0;
    pipe_mode_controller_if #(.COUNT_W(16)) bus ();
    pipe_mode_controller #(.NUM_OF_EXTRA_PIPES(2), .COUNT_W(16)) dut (
        .clk_pll (clk_pll),
        .rst_n   (rst_n),
        .bus     (bus)
    );
    always #5 clk_pll = ~clk_pll;

    task automatic cycle(input logic cv, input logic [1:0] cm, input logic [15:0] cb, input logic iv);
        @(posedge clk_pll);
        #1;
        bus.cfg_valid = cv;
        bus.cfg_mode  = cm;
        bus.cfg_beats = cb;
        bus.in_valid  = iv;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cycle(1'b0, 2'b00, 16'd0, 1'b0);
        #1;
        checks++;
        if ({bus.cfg_ready, bus.in_ready, bus.pipe_mode, bus.out_valid, bus.done, bus.busy, bus.err_mode} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset rdy/irdy/mode/ov/done/busy/err got %b want 10000000",
                     {bus.cfg_ready, bus.in_ready, bus.pipe_mode, bus.out_valid, bus.done, bus.busy, bus.err_mode});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_not_extended();
        logic [15:0] iv, ov, dn, cr, ir;
        iv = 16'h001E; ov = 16'h0078; dn = 16'h0040; cr = 16'h0181; ir = 16'h001E;
        for (int c = 0; c < 9; c++) begin
            cycle(c == 0, c == 0 ? 2'b10 : 2'b01, 16'd4, iv[c]);
            #1;
            checks++;
            if ({bus.out_valid, bus.done, bus.cfg_ready, bus.in_ready} !== {ov[c], dn[c], cr[c], ir[c]}) begin
                failures++;
                $display("FAIL not_ext c=%0d ov/done/rdy/irdy got %b want %b", c,
                         {bus.out_valid, bus.done, bus.cfg_ready, bus.in_ready}, {ov[c], dn[c], cr[c], ir[c]});
            end
            if (c == 1) begin
                checks++;
                if (bus.pipe_mode !== 2'b10 || bus.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL not_ext_mode got mode=%b busy=%b want mode=10 busy=1", bus.pipe_mode, bus.busy);
                end
            end
        end
    endtask

    task automatic test_extended_bubbles();
        logic [15:0] iv, ov, dn, cr, ir;
        iv = 16'h001A; ov = 16'h3400; dn = 16'h2000; cr = 16'hC001; ir = 16'h001E;
        for (int c = 0; c < 16; c++) begin
            cycle(c == 0, c == 0 ? 2'b11 : 2'b01, 16'd3, iv[c]);
            #1;
            checks++;
            if ({bus.out_valid, bus.done, bus.cfg_ready, bus.in_ready} !== {ov[c], dn[c], cr[c], ir[c]}) begin
                failures++;
                $display("FAIL extended c=%0d ov/done/rdy/irdy got %b want %b", c,
                         {bus.out_valid, bus.done, bus.cfg_ready, bus.in_ready}, {ov[c], dn[c], cr[c], ir[c]});
            end
        end
    endtask

    task automatic test_illegal_and_zero();
        logic [5:0] exp [5];
        exp = '{6'b1_0_11_0_0, 6'b1_1_11_0_0, 6'b1_1_11_0_0, 6'b1_1_00_1_0, 6'b1_1_00_0_0};
        for (int c = 0; c < 5; c++) begin
            cycle(c == 0 || c == 2, c == 0 ? 2'b01 : 2'b00, c == 0 ? 16'd5 : 16'd0, 1'b0);
            #1;
            checks++;
            if ({bus.cfg_ready, bus.err_mode, bus.pipe_mode, bus.done, bus.busy} !== exp[c]) begin
                failures++;
                $display("FAIL illegal_zero c=%0d rdy/err/mode/done/busy got %b want %b", c,
                         {bus.cfg_ready, bus.err_mode, bus.pipe_mode, bus.done, bus.busy}, exp[c]);
            end
        end
    endtask

    task automatic test_disabled();
        logic [15:0] iv, ov, dn, cr, ir;
        iv = 16'h001A; ov = 16'h000A; dn = 16'h0008; cr = 16'h0031; ir = 16'h000E;
        for (int c = 0; c < 6; c++) begin
            cycle(c == 0, c == 0 ? 2'b00 : 2'b01, 16'd2, iv[c]);
            #1;
            checks++;
            if ({bus.out_valid, bus.done, bus.cfg_ready, bus.in_ready} !== {ov[c], dn[c], cr[c], ir[c]}) begin
                failures++;
                $display("FAIL disabled c=%0d ov/done/rdy/irdy got %b want %b", c,
                         {bus.out_valid, bus.done, bus.cfg_ready, bus.in_ready}, {ov[c], dn[c], cr[c], ir[c]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] cv, ov, dn, cr, ir;
`ifdef PIPE_CTRL_BACKTOBACK_EN
        cv = 16'h0009; ov = 16'h00D8; dn = 16'h0090; cr = 16'h07C9; ir = 16'h0036;
`else
        cv = 16'h0039; ov = 16'h0318; dn = 16'h0210; cr = 16'h0421; ir = 16'h00C6;
`endif
        for (int c = 0; c < 11; c++) begin
            cycle(cv[c], 2'b10, 16'd2, 1'b1);
            #1;
            checks++;
            if ({bus.out_valid, bus.done, bus.cfg_ready, bus.in_ready} !== {ov[c], dn[c], cr[c], ir[c]}) begin
                failures++;
                $display("FAIL back_to_back c=%0d ov/done/rdy/irdy got %b want %b", c,
                         {bus.out_valid, bus.done, bus.cfg_ready, bus.in_ready}, {ov[c], dn[c], cr[c], ir[c]});
            end
        end
    endtask

    task automatic test_mode_hold();
        logic [15:0] cr, dn, ov, ir;
        logic [1:0]  pm;
        int n, dones;
        cr = 16'h0011; dn = 16'h0008; ov = 16'h0008; ir = 16'h0022;
        for (int c = 0; c < 6; c++) begin
            cycle(c < 5, c == 0 ? 2'b10 : 2'b11, 16'd1, 1'b1);
            #1;
            pm = c == 5 ? 2'b11 : 2'b10;
            checks++;
            if ({bus.out_valid, bus.done, bus.cfg_ready, bus.in_ready, bus.pipe_mode} !== {ov[c], dn[c], cr[c], ir[c], pm}) begin
                failures++;
                $display("FAIL mode_hold c=%0d ov/done/rdy/irdy/mode got %b want %b", c,
                         {bus.out_valid, bus.done, bus.cfg_ready, bus.in_ready, bus.pipe_mode}, {ov[c], dn[c], cr[c], ir[c], pm});
            end
        end
        n = 0;
        dones = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            cycle(1'b0, 2'b01, 16'd0, 1'b0);
            #1;
            if (bus.done === 1'b1) dones++;
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0 || dones != 1 || n != 10) begin
            failures++;
            $display("FAIL mode_hold_drain got busy=%b dones=%0d cycles=%0d want busy=0 dones=1 cycles=10", bus.busy, dones, n);
        end
    endtask

    task automatic test_reset_in_drain();
        for (int c = 0; c < 15; c++) begin
            cycle(c == 0, c == 0 ? 2'b11 : 2'b01, 16'd2, 1'b1);
            if (c == 5) rst_n = 1'b0;
            if (c == 6) rst_n = 1'b1;
            #1;
            if (c == 4) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_drain_pre got busy=%b irdy=%b want busy=1 irdy=0", bus.busy, bus.in_ready);
                end
            end
            if (c == 6) begin
                checks++;
                if ({bus.cfg_ready, bus.in_ready, bus.pipe_mode, bus.busy, bus.err_mode} !== 6'b10_00_00) begin
                    failures++;
                    $display("FAIL rst_drain_state rdy/irdy/mode/busy/err got %b want 100000",
                             {bus.cfg_ready, bus.in_ready, bus.pipe_mode, bus.busy, bus.err_mode});
                end
            end
            if (c >= 6) begin
                checks++;
                if ({bus.out_valid, bus.done} !== 2'b00) begin
                    failures++;
                    $display("FAIL rst_drain_stray c=%0d ov/done got %b want 00", c, {bus.out_valid, bus.done});
                end
            end
        end
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_mode  = 2'b00;
        bus.cfg_beats = 16'd0;
        bus.in_valid  = 1'b0;
        test_reset();
        test_not_extended();
        test_extended_bubbles();
        test_illegal_and_zero();
        test_disabled();
        test_back_to_back();
        test_mode_hold();
        test_reset_in_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
